// File: rtl/io_sim_pkg.sv
// Shared types for the simulated DLX bus slave: FSM state encoding and width helpers.
// Latency: none (types and constant functions only).
// Backpressure: n/a.
package io_sim_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    ACK     = 2'd2,
    RELEASE = 2'd3
  } state_e;

  // Number of active-low byte enables for a given bus width.
  function automatic int be_width(input int data_width);
    return data_width / 8;
  endfunction

  // Wait counter width: enough to hold the larger wait count, never zero bits.
  function automatic int cnt_width(input int wait_rd, input int wait_wr);
    int m;
    m = (wait_rd > wait_wr) ? wait_rd : wait_wr;
    return (m < 1) ? 1 : $clog2(m + 1);
  endfunction

endpackage

// File: rtl/io_sim_ram.sv
// Single-port behavioural RAM behind the simulated bus slave; byte-masked writes, contents not reset.
// Latency: read data registered, valid one cycle after addr; write commits on the clock edge with we=1.
// Backpressure: none, accepts an access every cycle.
// Ports: CLK_IN clock; addr word address; we write enable; be active-high byte enables;
//        wdata write data; rdata registered read data (old contents on a same-cycle write).
module io_sim_ram
  import io_sim_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32
) (
  input  logic                              CLK_IN,
  input  logic [ADDR_WIDTH-1:0]             addr,
  input  logic                              we,
  input  logic [be_width(DATA_WIDTH)-1:0]   be,
  input  logic [DATA_WIDTH-1:0]             wdata,
  output logic [DATA_WIDTH-1:0]             rdata
);

  localparam int BE_W = be_width(DATA_WIDTH);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
  logic [DATA_WIDTH-1:0] rdata_q;

  always_ff @(posedge CLK_IN) begin
    rdata_q <= mem[addr];
    if (we) begin
      for (int i = 0; i < BE_W; i++) begin
        if (be[i]) begin
          mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
        end
      end
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/io_sim_bus_slave.sv
// Simulated DLX external memory/IO slave: AS_N/WR_N strobe decode, programmable wait states, one-cycle ACK_N or BERR_N.
// Latency: first ACK_N/BERR_N cycle is WAIT_WR+1 (write) or WAIT_RD+1 (read) cycles after the edge that samples AS_N=0.
// Backpressure: a transaction completes or aborts before the next is accepted; IDLE lasts at least one cycle between them.
// Ports: CLK_IN/RST_IN/STEP_IN forwarded as CLK/RST/STEP; AS_N, WR_N, BE_N, MAO, MDO from the core;
//        ACK_N, BERR_N, DO (read data, zero outside a read ACK) and BUSY back to the core.
module io_sim_bus_slave
  import io_sim_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32,
  parameter int WAIT_RD    = 3,
  parameter int WAIT_WR    = 3,
  parameter int DEPTH      = 2**ADDR_WIDTH
) (
  input  logic                              CLK_IN,
  input  logic                              RST_IN,
  input  logic                              STEP_IN,
  input  logic                              AS_N,
  input  logic                              WR_N,
  input  logic [be_width(DATA_WIDTH)-1:0]   BE_N,
  input  logic [31:0]                       MAO,
  input  logic [DATA_WIDTH-1:0]             MDO,
  output logic                              CLK,
  output logic                              RST,
  output logic                              STEP,
  output logic                              ACK_N,
  output logic                              BERR_N,
  output logic [DATA_WIDTH-1:0]             DO,
  output logic                              BUSY
);

  localparam int          BE_W    = be_width(DATA_WIDTH);
  localparam int          CNT_W   = cnt_width(WAIT_RD, WAIT_WR);
  localparam logic [32:0] DEPTH_W = 33'(DEPTH);

  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic                   in_range_q, in_range_d;
  logic                   wr_q, wr_d;
  logic [BE_W-1:0]        be_n_q, be_n_d;
  logic [DATA_WIDTH-1:0]  wdata_q, wdata_d;

  logic                   mao_in_range;
  logic [CNT_W-1:0]       cnt_load;
  logic                   ram_we;
  logic [DATA_WIDTH-1:0]  ram_rdata;

  // Full 32-bit compare, so any address bit above the RAM index makes it out of range.
  assign mao_in_range = ({1'b0, MAO} < DEPTH_W);
  assign cnt_load     = WR_N ? CNT_W'(WAIT_RD) : CNT_W'(WAIT_WR);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    in_range_d = in_range_q;
    wr_d       = wr_q;
    be_n_d     = be_n_q;
    wdata_d    = wdata_q;
    case (state_q)
      IDLE: begin
        if (!AS_N) begin
          addr_d     = MAO[ADDR_WIDTH-1:0];
          in_range_d = mao_in_range;
          wr_d       = !WR_N;
          be_n_d     = BE_N;
          wdata_d    = MDO;
          cnt_d      = cnt_load;
          state_d    = (cnt_load == '0) ? ACK : WAIT;
        end
      end
      WAIT: begin
        // Early strobe release wins over a pending ACK: nothing is acknowledged or written.
        if (AS_N) begin
          state_d = IDLE;
        end else if (cnt_q > CNT_W'(1)) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          cnt_d   = '0;
          state_d = ACK;
        end
      end
      ACK:     state_d = RELEASE;
      RELEASE: if (AS_N) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK_IN or posedge RST_IN) begin
    if (RST_IN) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      addr_q     <= '0;
      in_range_q <= 1'b0;
      wr_q       <= 1'b0;
      be_n_q     <= '1;
      wdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      in_range_q <= in_range_d;
      wr_q       <= wr_d;
      be_n_q     <= be_n_d;
      wdata_q    <= wdata_d;
    end
  end

  // Write enable is decoded from the async-reset state, so a reset drops an uncommitted write.
  assign ram_we = (state_q == ACK) && in_range_q && wr_q;

  // The RAM reads addr_q every cycle; the last WAIT cycle's read lands in the ACK cycle.
  io_sim_ram #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_ram (
    .CLK_IN (CLK_IN),
    .addr   (addr_q),
    .we     (ram_we),
    .be     (~be_n_q),
    .wdata  (wdata_q),
    .rdata  (ram_rdata)
  );

  assign CLK    = CLK_IN;
  assign RST    = RST_IN;
  assign STEP   = STEP_IN;
  assign ACK_N  = !((state_q == ACK) && in_range_q);
  assign BERR_N = !((state_q == ACK) && !in_range_q);
  assign DO     = ((state_q == ACK) && in_range_q && !wr_q) ? ram_rdata : '0;
  assign BUSY   = (state_q != IDLE);

endmodule

// File: tb/tb_io_sim_bus_slave.sv
// Bench for io_sim_bus_slave: default-latency instance plus a WAIT_RD=1/WAIT_WR=0 instance on a shared bus.
// Latency: expected strobe cycle and data are queued when a transaction is driven and checked when the strobe appears.
// Backpressure: every wait is bounded; a missing strobe is reported and the run continues to the summary.
module tb_io_sim_bus_slave;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [3:0]  be_n;
    logic [31:0] wdata;
    bit          exp_ack;
    int          lat;
    logic [31:0] exp_do;
    int          hold;
  } vec_t;

  typedef struct {
    bit          is_ack;
    int          lat;
    logic [31:0] dat;
  } exp_t;

  logic        clk_in, rst_in, step_in, as_n, wr_n;
  logic [3:0]  be_n;
  logic [31:0] mao, mdo;
  logic        clk0, rst0, step0, ack_n0, berr_n0, busy0;
  logic        clk1, rst1, step1, ack_n1, berr_n1, busy1;
  logic [31:0] do0, do1;
  logic        sel;
  logic        ack_n, berr_n, busy;
  logic [31:0] dout;

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t sb[$];
  vec_t tbl0[10];
  vec_t tbl1[3];

  io_sim_bus_slave u_dut0 (
    .CLK_IN(clk_in), .RST_IN(rst_in), .STEP_IN(step_in), .AS_N(as_n), .WR_N(wr_n),
    .BE_N(be_n), .MAO(mao), .MDO(mdo), .CLK(clk0), .RST(rst0), .STEP(step0),
    .ACK_N(ack_n0), .BERR_N(berr_n0), .DO(do0), .BUSY(busy0)
  );

  io_sim_bus_slave #(.WAIT_RD(1), .WAIT_WR(0)) u_dut1 (
    .CLK_IN(clk_in), .RST_IN(rst_in), .STEP_IN(step_in), .AS_N(as_n), .WR_N(wr_n),
    .BE_N(be_n), .MAO(mao), .MDO(mdo), .CLK(clk1), .RST(rst1), .STEP(step1),
    .ACK_N(ack_n1), .BERR_N(berr_n1), .DO(do1), .BUSY(busy1)
  );

  always_comb begin
    ack_n  = sel ? ack_n1  : ack_n0;
    berr_n = sel ? berr_n1 : berr_n0;
    busy   = sel ? busy1   : busy0;
    dout   = sel ? do1     : do0;
  end

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // One bus transaction; expectation is queued at drive time, popped when a strobe appears.
  task automatic txn(input string nm, input logic wr, input logic [31:0] addr,
                     input logic [3:0] ben, input logic [31:0] wd, input bit exp_ack,
                     input int lat, input logic [31:0] exp_do, input int hold);
    exp_t e, x;
    bit   seen, stray, extra;
    int   cyc;
    @(negedge clk_in);
    as_n = 1'b0; wr_n = ~wr; mao = addr; be_n = ben; mdo = wd;
    e.is_ack = exp_ack; e.lat = lat; e.dat = exp_do;
    sb.push_back(e);
    seen = 0; stray = 0; extra = 0;
    for (cyc = 1; cyc <= 20 && !seen; cyc++) begin
      @(negedge clk_in);
      if (!ack_n || !berr_n) begin
        x = sb.pop_front();
        seen = 1;
        chk({nm, ".strobe"}, {30'b0, ack_n, berr_n}, x.is_ack ? 32'h1 : 32'h2);
        chk({nm, ".lat"}, 32'(cyc), 32'(x.lat));
        chk({nm, ".do"}, dout, x.dat);
      end else if (dout !== 32'h0) begin
        stray = 1;
      end
    end
    if (!seen) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s.timeout: got no strobe, expected one within 20 cycles", nm);
      void'(sb.pop_front());
    end
    chk({nm, ".do_idle"}, {31'b0, stray}, 32'h0);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk_in);
      if (!ack_n || !berr_n || dout !== 32'h0) extra = 1;
    end
    if (hold > 0) chk({nm, ".no_second"}, {31'b0, extra}, 32'h0);
    as_n = 1'b1;
    repeat (2) @(negedge clk_in);
    chk({nm, ".busy_after"}, {31'b0, busy}, 32'h0);
  endtask

  initial begin
    bit stray;

    tbl0[0] = '{1'b1, 32'h004,      4'b0000, 32'hDEADBEEF, 1'b1, 4, 32'h0,        0};
    tbl0[1] = '{1'b0, 32'h004,      4'b0000, 32'h0,        1'b1, 4, 32'hDEADBEEF, 0};
    tbl0[2] = '{1'b1, 32'h004,      4'b1010, 32'h11223344, 1'b1, 4, 32'h0,        0};
    tbl0[3] = '{1'b0, 32'h004,      4'b0000, 32'h0,        1'b1, 4, 32'hDE22BE44, 1};
    tbl0[4] = '{1'b1, 32'h008,      4'b0000, 32'hA5A50008, 1'b1, 4, 32'h0,        0};
    tbl0[5] = '{1'b1, 32'h3FF,      4'b0000, 32'h0F0F1234, 1'b1, 4, 32'h0,        0};
    tbl0[6] = '{1'b0, 32'h3FF,      4'b0000, 32'h0,        1'b1, 4, 32'h0F0F1234, 0};
    tbl0[7] = '{1'b0, 32'h400,      4'b0000, 32'h0,        1'b0, 4, 32'h0,        10};
    tbl0[8] = '{1'b1, 32'h80000004, 4'b0000, 32'h99999999, 1'b0, 4, 32'h0,        2};
    tbl0[9] = '{1'b0, 32'h004,      4'b0000, 32'h0,        1'b1, 4, 32'hDE22BE44, 0};

    tbl1[0] = '{1'b1, 32'h020,      4'b0000, 32'hA1B2C3D4, 1'b1, 1, 32'h0,        0};
    tbl1[1] = '{1'b0, 32'h020,      4'b0000, 32'h0,        1'b1, 2, 32'hA1B2C3D4, 0};
    tbl1[2] = '{1'b0, 32'h400,      4'b0000, 32'h0,        1'b0, 2, 32'h0,        3};

    sel = 1'b0; rst_in = 1'b1; step_in = 1'b0; as_n = 1'b1; wr_n = 1'b1;
    be_n = 4'hF; mao = 32'h0; mdo = 32'h0;

    // Reset state and pass-throughs.
    repeat (2) @(negedge clk_in);
    chk("rst.ack_n",  {31'b0, ack_n0},  32'h1);
    chk("rst.berr_n", {31'b0, berr_n0}, 32'h1);
    chk("rst.do",     do0,              32'h0);
    chk("rst.busy",   {31'b0, busy0},   32'h0);
    chk("rst.busy1",  {31'b0, busy1},   32'h0);
    chk("pass.rst",   {30'b0, rst0, rst1}, 32'h3);
    chk("pass.clk",   {30'b0, clk0, clk1}, 32'h0);
    rst_in  = 1'b0;
    step_in = 1'b1;
    #1;
    chk("pass.step",  {30'b0, step0, step1}, 32'h3);
    chk("pass.rst_lo", {30'b0, rst0, rst1}, 32'h0);
    step_in = 1'b0;

    for (int i = 0; i < 10; i++) begin
      txn($sformatf("d0v%0d", i), tbl0[i].wr, tbl0[i].addr, tbl0[i].be_n, tbl0[i].wdata,
          tbl0[i].exp_ack, tbl0[i].lat, tbl0[i].exp_do, tbl0[i].hold);
    end

    // Abort: strobe low for two sampled cycles of a write, then released.
    stray = 0;
    @(negedge clk_in);
    as_n = 1'b0; wr_n = 1'b0; mao = 32'h008; be_n = 4'h0; mdo = 32'h0000CAFE;
    repeat (2) begin
      @(negedge clk_in);
      if (!ack_n || !berr_n) stray = 1;
    end
    as_n = 1'b1;
    @(negedge clk_in);
    chk("abort.busy", {31'b0, busy}, 32'h0);
    repeat (4) begin
      @(negedge clk_in);
      if (!ack_n || !berr_n) stray = 1;
    end
    chk("abort.no_strobe", {31'b0, stray}, 32'h0);
    txn("abort.readback", 1'b0, 32'h008, 4'h0, 32'h0, 1'b1, 4, 32'hA5A50008, 0);

    // Reset in the middle of a write's wait states.
    txn("rstw.pre", 1'b1, 32'h010, 4'h0, 32'h12345678, 1'b1, 4, 32'h0, 0);
    stray = 0;
    @(negedge clk_in);
    as_n = 1'b0; wr_n = 1'b0; mao = 32'h010; be_n = 4'h0; mdo = 32'hFFFFFFFF;
    repeat (2) begin
      @(negedge clk_in);
      if (!ack_n || !berr_n) stray = 1;
    end
    rst_in = 1'b1;
    #1;
    chk("rstw.busy", {31'b0, busy}, 32'h0);
    @(negedge clk_in);
    rst_in = 1'b0;
    as_n   = 1'b1;
    repeat (5) begin
      @(negedge clk_in);
      if (!ack_n || !berr_n) stray = 1;
    end
    chk("rstw.no_strobe", {31'b0, stray}, 32'h0);
    txn("rstw.readback", 1'b0, 32'h010, 4'h0, 32'h0, 1'b1, 4, 32'h12345678, 0);

    // Short-latency instance.
    sel = 1'b1;
    for (int i = 0; i < 3; i++) begin
      txn($sformatf("d1v%0d", i), tbl1[i].wr, tbl1[i].addr, tbl1[i].be_n, tbl1[i].wdata,
          tbl1[i].exp_ack, tbl1[i].lat, tbl1[i].exp_do, tbl1[i].hold);
    end

    chk("sb.empty", 32'(sb.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
